ga_seq_ctrl: RTL and testbench
==============================

// Module: ga_seq_ctrl
// PURPOSE
//  Parametrised generation sequencer for the GA pipeline (RNG -> FIT -> SEL -> XOVER -> MUT).
//  - Primes the pipeline one stage per cycle and runs POP_SIZE/2 pair-slots of initial population.
//  - Then runs max_gen generations of POP_SIZE/2 pair-slots each, drains, and pulses done.
//  - Tracks the best chromosome/fitness seen. Supersedes the fixed 16-individual inline FSM.
// PARAMETERS
//  CHROM_W    32  chromosome width
//  FIT_W      27  signed fitness width
//  POP_SIZE   16  population size; even, >=2
//  GEN_W      16  generation counter width
//  STALL_GENS  8  generations without improvement before early stop (only used with GA_STALL_STOP_EN)
// PORTS
//  clk        in   1          clock, all state on rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  start      in   1          start request; sampled only in IDLE
//  abort      in   1          synchronous abort; returns to IDLE
//  max_gen    in   GEN_W      generation limit, captured at start
//  cand_valid in   1          fitness stage result valid this cycle
//  cand_chrom in   2xCHROM_W  pair of evaluated chromosomes [0],[1]
//  cand_fit   in   2xFIT_W    signed fitnesses of cand_chrom[0],[1]
//  rng_en     out  1          RNG stage enable
//  ff_en      out  1          fitness stage enable
//  sel_en     out  1          selection stage enable
//  xover_en   out  1          crossover enable
//  mut_en     out  1          mutation enable
//  busy       out  1          high from cycle after accepted start until DONE
//  done       out  1          one-cycle pulse on completion (not on abort)
//  stalled    out  1          completion was an early stop; tied 0 without macro
//  gen_count  out  GEN_W      completed generations
//  best       out  CHROM_W    best chromosome so far
//  best_fit   out  FIT_W      its fitness (signed)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; all enables, busy, done, stalled = 0; gen_count = 0;
//   best = 0; best_fit = most negative FIT_W value. Deassertion takes effect at the next clk edge.
//  States: IDLE -> FILL -> INIT_POP -> EVOLVE -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 -> FILL next cycle; capture max_gen; clear gen_count, best, best_fit, stall counter.
//  FILL (4 cycles, k=0..3): rng_en, ff_en, sel_en, xover_en asserted at k=0,1,2,3 respectively and
//   held; mut_en low. xover_en drops again on leaving FILL.
//  INIT_POP (POP_SIZE/2 cycles): initial individuals pass through; xover_en=0, mut_en=0.
//  EVOLVE: xover_en=mut_en=1. Pair counter 0..POP_SIZE/2-1; on wrap gen_count increments.
//   When gen_count reaches captured max_gen -> DRAIN. max_gen=0: INIT_POP goes straight to DRAIN.
//  DRAIN (5 cycles): enables drop in pipeline order, one per cycle (rng first, mut last).
//  DONE (1 cycle): done=1, busy=0 -> IDLE. best/best_fit/gen_count hold until next start.
//  abort=1 in any non-IDLE state: next cycle IDLE, all enables 0, busy 0, no done; results hold.
//   abort has priority over every transition. start while busy is ignored.
//  Best tracking (any state except IDLE): on cand_valid, pick larger of cand_fit[0]/[1] (signed;
//   tie -> [0]); replace best only if strictly greater than best_fit. Equal fitness keeps old best.
//  gen_count saturates at all-ones; never wraps.
// CONFIGURATION
//  GA_STALL_STOP_EN defined: stall counter clears on any best update, increments per completed
//   generation otherwise; reaching STALL_GENS -> DRAIN and stalled=1 with the done pulse
//   (held until next start). Not defined: counter absent, stalled tied 0, runs full max_gen.
// STRUCTURE
//  ga_pkg: ga_seq_state_t enum, GA_STAGES=5 constant, fitness typedef helper, FIT_MIN function.
//  Sub-module ga_best_tracker: pair compare + strict-greater best register, update strobe out
//   (used by stall counter).
// TESTING
//  1 Reset mid-EVOLVE (reset_n=0 for 1 cycle) -> all outputs at reset values same cycle, IDLE.
//  2 POP_SIZE=16, max_gen=3, start -> busy next cycle; FILL 4 + INIT 8 + EVOLVE 24 + DRAIN 5;
//    done pulses once, gen_count=3.
//  3 cand_fit pairs (-5,-9),(7,7),(7,3) -> best_fit -5, then 7 from [0]; third keeps earlier best.
//  4 max_gen=0 -> no cycle with xover_en=1 after FILL; done with gen_count=0.
//  5 abort during EVOLVE gen 1 -> IDLE next cycle, enables 0, no done, best retained.
//  6 GA_STALL_STOP_EN, STALL_GENS=2, max_gen=10, no improvement after gen 0 -> done, stalled=1, gen_count=2.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared types and constants for the GA generation sequencer.
//  ga_seq_state_t : sequencer state encoding
//  GA_STAGES      : number of pipeline stages (RNG, FIT, SEL, XOVER, MUT)
//  FILL_CYCLES    : cycles spent priming the pipeline before the initial population
//  ga_fit_t       : fitness type at the default fitness width
//  FIT_MIN()      : most negative value of a signed field of the given width (low bits)
package ga_pkg;

    localparam int unsigned GA_STAGES   = 5;
    localparam int unsigned FILL_CYCLES = 4;
    localparam int unsigned GA_FIT_W    = 27;

    typedef logic signed [GA_FIT_W-1:0] ga_fit_t;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StInitPop,
        StEvolve,
        StDrain,
        StDone
    } ga_seq_state_t;

    // Only the sign bit of a width-bit field is set; callers truncate to width.
    function automatic logic [63:0] FIT_MIN(input int unsigned width);
        logic [63:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ga_best_tracker.sv
// Best-chromosome tracker for the GA sequencer.
// Picks the fitter of an evaluated pair (signed, tie -> [0]) and replaces the stored best only
// when strictly greater than the current best fitness.
// Ports:
//  clk, reset_n  clock, asynchronous active-low reset
//  clear         synchronous clear to reset values (new run)
//  track_en      candidate pair is valid and tracking is active
//  cand_chrom    pair of chromosomes, [0] in the low half
//  cand_fit      pair of signed fitnesses, [0] in the low half
//  best          best chromosome so far
//  best_fit      its signed fitness
//  update        strobe: best is being replaced this cycle
module ga_best_tracker
    import ga_pkg::*;
#(
    parameter int unsigned CHROM_W = 32,
    parameter int unsigned FIT_W   = 27
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 track_en,
    input  logic [2*CHROM_W-1:0] cand_chrom,
    input  logic [2*FIT_W-1:0]   cand_fit,
    output logic [CHROM_W-1:0]   best,
    output logic [FIT_W-1:0]     best_fit,
    output logic                 update
);

    localparam logic [FIT_W-1:0] FitMinV = FIT_W'(FIT_MIN(FIT_W));

    logic signed [FIT_W-1:0] fit0, fit1, win_fit, best_fit_q;
    logic        [CHROM_W-1:0] win_chrom, best_q;
    logic                      pick1;

    assign fit0 = cand_fit[FIT_W-1:0];
    assign fit1 = cand_fit[2*FIT_W-1:FIT_W];

    always_comb begin
        pick1     = fit1 > fit0;
        win_fit   = pick1 ? fit1 : fit0;
        win_chrom = pick1 ? cand_chrom[2*CHROM_W-1:CHROM_W] : cand_chrom[CHROM_W-1:0];
        update    = track_en && (win_fit > best_fit_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_q     <= '0;
            best_fit_q <= FitMinV;
        end else if (clear) begin
            best_q     <= '0;
            best_fit_q <= FitMinV;
        end else if (update) begin
            best_q     <= win_chrom;
            best_fit_q <= win_fit;
        end
    end

    assign best     = best_q;
    assign best_fit = best_fit_q;

endmodule

// File: rtl/ga_seq_ctrl.sv
// Generation sequencer for the GA pipeline (RNG -> FIT -> SEL -> XOVER -> MUT).
// Primes the pipeline one stage per cycle, streams POP_SIZE/2 pair-slots of initial population,
// runs max_gen generations of POP_SIZE/2 pair-slots, drains in pipeline order and pulses done.
// Optional feature macro: GA_STALL_STOP_EN (early stop after STALL_GENS generations without a
// best-fitness improvement; stalled reports it). Without it, stalled is tied low.
// Ports:
//  clk, reset_n    clock, asynchronous active-low reset
//  start, abort    start request (IDLE only), synchronous abort back to IDLE
//  max_gen         generation limit, captured at start
//  cand_valid      fitness-stage pair valid; cand_chrom / cand_fit carry the pair
//  rng_en..mut_en  stage enables
//  busy, done      run in progress, one-cycle completion pulse
//  stalled         completion was an early stop
//  gen_count       completed generations (saturating)
//  best, best_fit  best chromosome and its signed fitness
module ga_seq_ctrl
    import ga_pkg::*;
#(
    parameter int unsigned CHROM_W    = 32,
    parameter int unsigned FIT_W      = 27,
    parameter int unsigned POP_SIZE   = 16,
    parameter int unsigned GEN_W      = 16,
    parameter int unsigned STALL_GENS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [GEN_W-1:0]     max_gen,
    input  logic                 cand_valid,
    input  logic [2*CHROM_W-1:0] cand_chrom,
    input  logic [2*FIT_W-1:0]   cand_fit,
    output logic                 rng_en,
    output logic                 ff_en,
    output logic                 sel_en,
    output logic                 xover_en,
    output logic                 mut_en,
    output logic                 busy,
    output logic                 done,
    output logic                 stalled,
    output logic [GEN_W-1:0]     gen_count,
    output logic [CHROM_W-1:0]   best,
    output logic [FIT_W-1:0]     best_fit
);

    localparam int unsigned HALF  = POP_SIZE / 2;
    localparam int unsigned CNT_W = $clog2(POP_SIZE + 8);

    ga_seq_state_t          state_q;
    logic [GA_STAGES-1:0]   en_q, en_drop;
    logic [CNT_W-1:0]       cnt_q;
    logic [GEN_W-1:0]       gen_q, gen_inc, max_gen_q;
    logic                   busy_q, done_q;
    logic                   run_start, best_upd, stall_hit;

    assign run_start = (state_q == StIdle) && start;

    ga_best_tracker #(
        .CHROM_W (CHROM_W),
        .FIT_W   (FIT_W)
    ) u_best (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (run_start),
        .track_en   (cand_valid && (state_q != StIdle)),
        .cand_chrom (cand_chrom),
        .cand_fit   (cand_fit),
        .best       (best),
        .best_fit   (best_fit),
        .update     (best_upd)
    );

    always_comb begin
        gen_inc = (gen_q == '1) ? gen_q : gen_q + 1'b1;
        // Drop the lowest still-active stage: enables fall in pipeline order.
        en_drop = en_q & {en_q[GA_STAGES-2:0], 1'b0};
    end

`ifdef GA_STALL_STOP_EN
    logic [GEN_W-1:0] stall_q, stall_nxt;
    logic             stall_stop_q, stalled_q;

    always_comb begin
        stall_nxt = best_upd ? '0 : stall_q + 1'b1;
        stall_hit = stall_nxt >= GEN_W'(STALL_GENS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q      <= '0;
            stall_stop_q <= 1'b0;
            stalled_q    <= 1'b0;
        end else if (run_start) begin
            stall_q      <= '0;
            stall_stop_q <= 1'b0;
            stalled_q    <= 1'b0;
        end else if (state_q != StIdle && !abort) begin
            if (state_q == StEvolve && cnt_q == CNT_W'(HALF - 1)) begin
                stall_q <= stall_nxt;
                if (stall_hit) stall_stop_q <= 1'b1;
            end else if (best_upd) begin
                stall_q <= '0;
            end
            if (state_q == StDrain && cnt_q == CNT_W'(GA_STAGES - 1)) stalled_q <= stall_stop_q;
        end
    end

    assign stalled = stalled_q;
`else
    logic unused_cfg;
    assign stall_hit  = 1'b0;
    assign stalled    = 1'b0;
    assign unused_cfg = ^{STALL_GENS, best_upd};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            en_q      <= '0;
            cnt_q     <= '0;
            gen_q     <= '0;
            max_gen_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort && state_q != StIdle) begin
            // Abort beats every transition; results are left untouched.
            state_q <= StIdle;
            en_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= StFill;
                        en_q      <= GA_STAGES'(1);
                        cnt_q     <= '0;
                        gen_q     <= '0;
                        max_gen_q <= max_gen;
                        busy_q    <= 1'b1;
                    end
                end
                StFill: begin
                    if (cnt_q == CNT_W'(FILL_CYCLES - 1)) begin
                        state_q <= StInitPop;
                        en_q[3] <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        en_q  <= {en_q[GA_STAGES-2:0], 1'b1};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StInitPop: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q <= '0;
                        if (max_gen_q == '0) begin
                            state_q <= StDrain;
                            en_q    <= en_drop;
                        end else begin
                            state_q <= StEvolve;
                            en_q    <= '1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StEvolve: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q <= '0;
                        gen_q <= gen_inc;
                        if (gen_inc == max_gen_q || stall_hit) begin
                            state_q <= StDrain;
                            en_q    <= en_drop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (cnt_q == CNT_W'(GA_STAGES - 1)) begin
                        state_q <= StDone;
                        en_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        en_q  <= en_drop;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    en_q    <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rng_en    = en_q[0];
    assign ff_en     = en_q[1];
    assign sel_en    = en_q[2];
    assign xover_en  = en_q[3];
    assign mut_en    = en_q[4];
    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_ga_seq_ctrl.sv
// Directed bench for ga_seq_ctrl with hand-computed expected values.
module tb_ga_seq_ctrl;

    localparam int CHROM_W = 32;
    localparam int FIT_W   = 27;
    localparam int GEN_W   = 16;

    logic                 clk = 1'b0;
    logic                 reset_n, start, abort, cand_valid;
    logic [GEN_W-1:0]     max_gen;
    logic [2*CHROM_W-1:0] cand_chrom;
    logic [2*FIT_W-1:0]   cand_fit;
    logic                 rng_en, ff_en, sel_en, xover_en, mut_en, busy, done, stalled;
    logic [GEN_W-1:0]     gen_count;
    logic [CHROM_W-1:0]   best;
    logic [FIT_W-1:0]     best_fit;

    ga_seq_ctrl #(
        .CHROM_W    (CHROM_W),
        .FIT_W      (FIT_W),
        .POP_SIZE   (16),
        .GEN_W      (GEN_W),
        .STALL_GENS (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .max_gen    (max_gen),
        .cand_valid (cand_valid),
        .cand_chrom (cand_chrom),
        .cand_fit   (cand_fit),
        .rng_en     (rng_en),
        .ff_en      (ff_en),
        .sel_en     (sel_en),
        .xover_en   (xover_en),
        .mut_en     (mut_en),
        .busy       (busy),
        .done       (done),
        .stalled    (stalled),
        .gen_count  (gen_count),
        .best       (best),
        .best_fit   (best_fit)
    );

    always #5 clk = ~clk;

    localparam logic [FIT_W-1:0] FitMin = 27'h4000000;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Best-tracking table: pairs fed in cycles 0..3 and the best expected one cycle later.
    logic [CHROM_W-1:0] tc0 [4] = '{32'h11111111, 32'h33333333, 32'h55555555, 32'h66666666};
    logic [CHROM_W-1:0] tc1 [4] = '{32'h22222222, 32'h44444444, 32'h00000000, 32'h77777777};
    logic [FIT_W-1:0]   tf0 [4] = '{27'h7FFFFFB, 27'd7, 27'd7, 27'd2};
    logic [FIT_W-1:0]   tf1 [4] = '{27'h7FFFFF7, 27'd7, 27'd3, 27'd9};
    logic [CHROM_W-1:0] eb  [4] = '{32'h11111111, 32'h33333333, 32'h33333333, 32'h77777777};
    logic [FIT_W-1:0]   ef  [4] = '{27'h7FFFFFB, 27'd7, 27'd7, 27'd9};

    logic [4:0]       en_log  [128];
    logic [GEN_W-1:0] gen_log [128];
    int feed_mode, done_cnt, done_cyc, busy_cnt, xover_late;

    // Starts a run from IDLE and samples every cycle at the falling edge; cycle 0 is the first
    // cycle after the accepting edge.
    task automatic run_job(input logic [GEN_W-1:0] mg, input int abort_at, input int limit);
        max_gen = mg;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; xover_late = 0;
        for (int c = 0; c < limit; c++) begin
            en_log[c]  = {mut_en, xover_en, sel_en, ff_en, rng_en};
            gen_log[c] = gen_count;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (c >= 4 && xover_en) xover_late++;
            if (c == 0) begin
                check_eq("best_cleared", 64'(best), 64'(0));
                check_eq("fit_cleared", 64'(best_fit), 64'(FitMin));
            end
            if (feed_mode == 1 && c >= 1 && c <= 4) begin
                check_eq($sformatf("best_%0d", c), 64'(best), 64'(eb[c-1]));
                check_eq($sformatf("best_fit_%0d", c), 64'(best_fit), 64'(ef[c-1]));
            end
            cand_valid = 1'b0;
            if (feed_mode == 1 && c < 4) begin
                cand_valid = 1'b1;
                cand_chrom = {tc1[c], tc0[c]};
                cand_fit   = {tf1[c], tf0[c]};
            end else if (feed_mode == 2 && c == 0) begin
                cand_valid = 1'b1;
                cand_chrom = {32'h0, 32'hABCD0123};
                cand_fit   = {27'd50, 27'd100};
            end
            abort = (c == abort_at);
            // A start while busy must be ignored, including its max_gen.
            start = (c == 5);
            if (c == 5) max_gen = 16'd7;
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0; cand_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; max_gen = '0;
        cand_valid = 1'b0; cand_chrom = '0; cand_fit = '0; feed_mode = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_en", 64'({mut_en, xover_en, sel_en, ff_en, rng_en}), 64'(0));
        check_eq("rst_busy_done", 64'({busy, done, stalled}), 64'(0));
        check_eq("rst_gen", 64'(gen_count), 64'(0));
        check_eq("rst_best", 64'(best), 64'(0));
        check_eq("rst_best_fit", 64'(best_fit), 64'(FitMin));
        reset_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of EVOLVE.
        max_gen = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cand_valid = 1'b1;
        cand_chrom = {32'h0, 32'h0BADF00D}; cand_fit = {27'd0, 27'd5};
        @(negedge clk);
        cand_valid = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("pre_rst_evolve", 64'({busy, xover_en, mut_en}), 64'(3'b111));
        check_eq("pre_rst_best", 64'(best), 64'(32'h0BADF00D));
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_en", 64'({mut_en, xover_en, sel_en, ff_en, rng_en}), 64'(0));
        check_eq("mid_rst_busy", 64'({busy, done}), 64'(0));
        check_eq("mid_rst_best", 64'(best), 64'(0));
        check_eq("mid_rst_fit", 64'(best_fit), 64'(FitMin));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", 64'({busy, rng_en}), 64'(0));

        // Full run, max_gen=3, with best-tracking pairs.
        feed_mode = 1;
        run_job(16'd3, -1, 50);
        check_eq("run_done_cnt", 64'(done_cnt), 64'(1));
        check_eq("run_done_cyc", 64'(done_cyc), 64'(41));
        check_eq("run_busy_cyc", 64'(busy_cnt), 64'(41));
        check_eq("fill_0", 64'(en_log[0]), 64'(5'b00001));
        check_eq("fill_1", 64'(en_log[1]), 64'(5'b00011));
        check_eq("fill_3", 64'(en_log[3]), 64'(5'b01111));
        check_eq("init_0", 64'(en_log[4]), 64'(5'b00111));
        check_eq("evolve_0", 64'(en_log[12]), 64'(5'b11111));
        check_eq("evolve_last", 64'(en_log[35]), 64'(5'b11111));
        check_eq("drain_0", 64'(en_log[36]), 64'(5'b11110));
        check_eq("drain_3", 64'(en_log[39]), 64'(5'b10000));
        check_eq("drain_4", 64'(en_log[40]), 64'(5'b00000));
        check_eq("gen_c19", 64'(gen_log[19]), 64'(0));
        check_eq("gen_c20", 64'(gen_log[20]), 64'(1));
        check_eq("run_gen", 64'(gen_count), 64'(3));
        check_eq("run_best_hold", 64'(best), 64'(32'h77777777));
        check_eq("run_stalled", 64'(stalled), 64'(0));

        // max_gen=0: INIT_POP straight to DRAIN.
        feed_mode = 0;
        run_job(16'd0, -1, 30);
        check_eq("mg0_xover", 64'(xover_late), 64'(0));
        check_eq("mg0_done_cyc", 64'(done_cyc), 64'(17));
        check_eq("mg0_busy_cyc", 64'(busy_cnt), 64'(17));
        check_eq("mg0_drain_0", 64'(en_log[12]), 64'(5'b00110));
        check_eq("mg0_gen", 64'(gen_count), 64'(0));

        // Abort during generation 1.
        feed_mode = 2;
        run_job(16'd3, 22, 60);
        check_eq("abort_pre_en", 64'(en_log[22]), 64'(5'b11111));
        check_eq("abort_en", 64'(en_log[23]), 64'(0));
        check_eq("abort_busy_cyc", 64'(busy_cnt), 64'(23));
        check_eq("abort_no_done", 64'(done_cnt), 64'(0));
        check_eq("abort_gen", 64'(gen_count), 64'(1));
        check_eq("abort_best", 64'(best), 64'(32'hABCD0123));
        check_eq("abort_fit", 64'(best_fit), 64'(27'd100));

`ifdef GA_STALL_STOP_EN
        // Improvements only before generation 1 completes: stop after 2 stale generations.
        feed_mode = 1;
        run_job(16'd10, -1, 60);
        check_eq("stall_done_cyc", 64'(done_cyc), 64'(33));
        check_eq("stall_gen", 64'(gen_count), 64'(2));
        check_eq("stall_flag", 64'(stalled), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
